// File: rtl/regfile_mp_pkg.sv
// Shared types and helpers for the 2-read/1-write register file.
package regfile_mp_pkg;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } clr_state_e;

    // Widest word be_merge handles; callers zero-extend and truncate around it.
    localparam int MAX_DW = 256;
    localparam int MAX_BE = MAX_DW / 8;

    function automatic int depth_of(input int addr_width);
        return 1 << addr_width;
    endfunction

    function automatic logic [MAX_DW-1:0] be_merge(
        input logic [MAX_DW-1:0] old_word,
        input logic [MAX_DW-1:0] new_word,
        input logic [MAX_BE-1:0] be
    );
        logic [MAX_DW-1:0] res;
        res = old_word;
        for (int k = 0; k < MAX_BE; k++) begin
            if (be[k]) begin
                res[8*k +: 8] = new_word[8*k +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/regfile_mp_if.sv
// Write and dual-read port bundle for regfile_mp.
interface regfile_mp_if #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 4
);
    logic                    i_wr_en;
    logic [ADDR_WIDTH-1:0]   i_wr_addr;
    logic [DATA_WIDTH-1:0]   i_wr_data;
    logic [DATA_WIDTH/8-1:0] i_wr_be;
    logic [ADDR_WIDTH-1:0]   i_rd_addr_a;
    logic [ADDR_WIDTH-1:0]   i_rd_addr_b;
    logic [DATA_WIDTH-1:0]   o_rd_data_a;
    logic [DATA_WIDTH-1:0]   o_rd_data_b;
    logic                    o_init_busy;

    modport master (
        output i_wr_en, i_wr_addr, i_wr_data, i_wr_be, i_rd_addr_a, i_rd_addr_b,
        input  o_rd_data_a, o_rd_data_b, o_init_busy
    );

    modport slave (
        input  i_wr_en, i_wr_addr, i_wr_data, i_wr_be, i_rd_addr_a, i_rd_addr_b,
        output o_rd_data_a, o_rd_data_b, o_init_busy
    );
endinterface

// File: rtl/regfile_mp_clear_fsm.sv
// Post-reset clear sweep: ST_CLEAR | zeroing entry[ptr], one per cycle
//                        ST_READY | sweep done, user access open
module regfile_mp_clear_fsm
    import regfile_mp_pkg::*;
#(
    parameter int ADDR_WIDTH     = 4,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic                  busy,
    output logic                  clr_we,
    output logic [ADDR_WIDTH-1:0] clr_addr
);

    localparam clr_state_e RST_STATE = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;

    clr_state_e            state, state_nxt;
    logic [ADDR_WIDTH-1:0] ptr, ptr_nxt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= RST_STATE;
            ptr   <= '0;
        end else begin
            state <= state_nxt;
            ptr   <= ptr_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        busy      = 1'b0;
        clr_we    = 1'b0;
        case (state)
            ST_CLEAR: begin
                busy    = 1'b1;
                // The array is never written while reset is held.
                clr_we  = rst_n;
                ptr_nxt = ptr + 1'b1;
                if (ptr == {ADDR_WIDTH{1'b1}}) begin
                    state_nxt = ST_READY;
                end
            end
            default: begin
            end
        endcase
    end

    assign clr_addr = ptr;

endmodule

// File: rtl/regfile_mp.sv
// 2-read/1-write register file with byte-enable writes, selectable read latency,
// optional write-to-read bypass and a post-reset clear sweep.
module regfile_mp
    import regfile_mp_pkg::*;
#(
    parameter int DATA_WIDTH     = 16,
    parameter int ADDR_WIDTH     = 4,
    parameter int READ_LATENCY   = 0,
    parameter int BYPASS         = 1,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    regfile_mp_if.slave  bus
);

    localparam int DEPTH  = depth_of(ADDR_WIDTH);
    localparam int NBYTES = DATA_WIDTH / 8;

    logic [DATA_WIDTH-1:0]      mem [DEPTH];
    logic                       busy;
    logic                       clr_we;
    logic [ADDR_WIDTH-1:0]      clr_addr;
    logic                       user_we;
    logic [DATA_WIDTH-1:0]      wr_merged;
    logic [1:0][ADDR_WIDTH-1:0] rd_addr;
    logic [1:0][DATA_WIDTH-1:0] rd_data;

    function automatic logic [DATA_WIDTH-1:0] merge_word(
        input logic [DATA_WIDTH-1:0] old_word,
        input logic [DATA_WIDTH-1:0] new_word,
        input logic [NBYTES-1:0]     be
    );
        return DATA_WIDTH'(be_merge(MAX_DW'(old_word), MAX_DW'(new_word), MAX_BE'(be)));
    endfunction

    regfile_mp_clear_fsm #(
        .ADDR_WIDTH     (ADDR_WIDTH),
        .CLEAR_ON_RESET (CLEAR_ON_RESET)
    ) u_clear_fsm (
        .clk      (clk),
        .rst_n    (rst_n),
        .busy     (busy),
        .clr_we   (clr_we),
        .clr_addr (clr_addr)
    );

    // Writes during the sweep are dropped, not deferred.
    assign user_we   = bus.i_wr_en & ~busy & rst_n;
    assign wr_merged = merge_word(mem[bus.i_wr_addr], bus.i_wr_data, bus.i_wr_be);

    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem[clr_addr] <= '0;
        end else if (user_we) begin
            mem[bus.i_wr_addr] <= wr_merged;
        end
    end

    assign rd_addr         = {bus.i_rd_addr_b, bus.i_rd_addr_a};
    assign bus.o_rd_data_a = rd_data[0];
    assign bus.o_rd_data_b = rd_data[1];
    assign bus.o_init_busy = busy;

    for (genvar p = 0; p < 2; p++) begin : g_port
        logic [DATA_WIDTH-1:0] fwd;

        if (BYPASS != 0) begin : g_byp
            // A hit returns the merged word, so unenabled bytes still come from the array.
            assign fwd = (user_we && (bus.i_wr_addr == rd_addr[p])) ? wr_merged
                                                                     : mem[rd_addr[p]];
        end else begin : g_raw
            assign fwd = mem[rd_addr[p]];
        end

        if (READ_LATENCY == 0) begin : g_comb
            assign rd_data[p] = busy ? '0 : fwd;
        end else begin : g_reg
            logic [DATA_WIDTH-1:0] rd_q;
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    rd_q <= '0;
                end else begin
                    rd_q <= busy ? '0 : fwd;
                end
            end
            assign rd_data[p] = rd_q;
        end
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench: five regfile_mp variants share one stimulus stream and are
// checked against a byte-level array model.
module tb_regfile_mp;

    localparam int NDUT  = 5;
    localparam int DW    = 16;
    localparam int AW    = 4;
    localparam int DEPTH = 16;

    function automatic int lat_of(input int g); return (g >= 2) ? 1 : 0; endfunction
    function automatic int byp_of(input int g); return (g == 0 || g == 3) ? 1 : 0; endfunction
    function automatic int clr_of(input int g); return (g < 4) ? 1 : 0; endfunction

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          wr_en = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [DW-1:0] wr_data = '0;
    logic [1:0]    wr_be = '0;
    logic [AW-1:0] rd_addr_a = '0;
    logic [AW-1:0] rd_addr_b = '0;

    logic [NDUT-1:0][DW-1:0] rd_a, rd_b;
    logic [NDUT-1:0]         busy_o;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        regfile_mp_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();
        assign bus.i_wr_en     = wr_en;
        assign bus.i_wr_addr   = wr_addr;
        assign bus.i_wr_data   = wr_data;
        assign bus.i_wr_be     = wr_be;
        assign bus.i_rd_addr_a = rd_addr_a;
        assign bus.i_rd_addr_b = rd_addr_b;
        assign rd_a[g]         = bus.o_rd_data_a;
        assign rd_b[g]         = bus.o_rd_data_b;
        assign busy_o[g]       = bus.o_init_busy;

        regfile_mp #(
            .DATA_WIDTH     (DW),
            .ADDR_WIDTH     (AW),
            .READ_LATENCY   (lat_of(g)),
            .BYPASS         (byp_of(g)),
            .CLEAR_ON_RESET (clr_of(g))
        ) dut (
            .clk   (clk),
            .rst_n (rst_n),
            .bus   (bus.slave)
        );
    end

    // Reference model: contents seen by swept variants and by the no-sweep variant.
    logic [DW-1:0] mem    [DEPTH];
    logic [DW-1:0] mem_nc [DEPTH];
    int            sweep_left = 0;
    bit            nc_known = 1'b0;
    int            cyc = 0;
    int            n_checks = 0;
    int            n_pass = 0;

    typedef struct {
        int          due;
        int          dut;
        bit          chk_busy;
        bit          exp_busy;
        bit          chk_data;
        logic [DW-1:0] ea;
        logic [DW-1:0] eb;
    } exp_t;

    exp_t sb[$];
    exp_t me;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic logic [DW-1:0] merge16(input logic [DW-1:0] o, input logic [DW-1:0] n,
                                              input logic [1:0] be);
        return {be[1] ? n[15:8] : o[15:8], be[0] ? n[7:0] : o[7:0]};
    endfunction

    // Value a port of variant g should see for address a given the inputs now applied.
    function automatic logic [DW-1:0] read_now(input int g, input logic [AW-1:0] a);
        logic [DW-1:0] v;
        v = (clr_of(g) != 0) ? mem[a] : mem_nc[a];
        if (!rst_n) return '0;
        if (clr_of(g) != 0 && sweep_left > 0) return '0;
        if (byp_of(g) != 0 && wr_en && wr_addr == a) v = merge16(v, wr_data, wr_be);
        return v;
    endfunction

    task automatic step(input bit rst, input bit we, input logic [AW-1:0] wa,
                        input logic [DW-1:0] wd, input logic [1:0] be,
                        input logic [AW-1:0] ra, input logic [AW-1:0] rb);
        exp_t e;
        @(posedge clk);
        #1;
        rst_n = rst; wr_en = we; wr_addr = wa; wr_data = wd; wr_be = be;
        rd_addr_a = ra; rd_addr_b = rb;
        if (rst) begin
            for (int g = 0; g < NDUT; g++) begin
                e.due      = cyc;
                e.dut      = g;
                e.chk_busy = 1'b1;
                e.exp_busy = (clr_of(g) != 0) && (sweep_left > 0);
                e.chk_data = (lat_of(g) == 0) && (clr_of(g) != 0 || nc_known);
                e.ea       = read_now(g, ra);
                e.eb       = read_now(g, rb);
                sb.push_back(e);
            end
        end
        for (int g = 0; g < NDUT; g++) begin
            if (lat_of(g) != 0) begin
                e.due      = cyc + 1;
                e.dut      = g;
                e.chk_busy = 1'b0;
                e.exp_busy = 1'b0;
                e.chk_data = (clr_of(g) != 0) || nc_known;
                e.ea       = read_now(g, ra);
                e.eb       = read_now(g, rb);
                sb.push_back(e);
            end
        end
        if (!rst) begin
            // Nothing is readable until the following sweep has zeroed everything.
            for (int i = 0; i < DEPTH; i++) mem[i] = '0;
            sweep_left = DEPTH;
        end else begin
            if (we) mem_nc[wa] = merge16(mem_nc[wa], wd, be);
            if (we && sweep_left == 0) mem[wa] = merge16(mem[wa], wd, be);
            if (sweep_left > 0) sweep_left--;
        end
        @(negedge clk);
    endtask

    task automatic idle(input logic [AW-1:0] ra, input logic [AW-1:0] rb);
        step(1'b1, 1'b0, '0, '0, 2'b00, ra, rb);
    endtask

    // Releases reset and watches busy; already-swept entry 0 is hammered with writes.
    task automatic sweep_watch();
        for (int i = 0; i <= DEPTH; i++) begin
            step(1'b1, (i > 0 && i < DEPTH), 4'd0, 16'hDEAD, 2'b11, 4'(i), 4'd0);
            check("sweep busy", 32'(busy_o[0]), 32'(i < DEPTH));
        end
    endtask

    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].due <= cyc) begin
            me = sb.pop_front();
            if (me.due != cyc) check("scoreboard due", 32'(cyc), 32'(me.due));
            if (me.chk_busy)
                check($sformatf("d%0d init_busy", me.dut), 32'(busy_o[3'(me.dut)]), 32'(me.exp_busy));
            if (me.chk_data) begin
                check($sformatf("d%0d rd_a", me.dut), 32'(rd_a[3'(me.dut)]), 32'(me.ea));
                check($sformatf("d%0d rd_b", me.dut), 32'(rd_b[3'(me.dut)]), 32'(me.eb));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running, required finish");
        $fatal(1);
    end

    initial begin
        logic [AW-1:0] r_wa, r_ra, r_rb;
        logic [DW-1:0] r_wd;
        logic [1:0]    r_be;
        bit            r_we;

        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, '0, '0, 2'b00, '0, '0);

        // Sweep length, dropped writes, then every entry reads zero.
        sweep_watch();
        for (int i = 0; i < DEPTH; i++) begin
            idle(4'(i), 4'(DEPTH - 1 - i));
            check("post-sweep rd_a", 32'(rd_a[0]), 32'h0);
        end

        // Give the no-sweep variant known contents.
        for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b1, 4'(i), 16'h0000, 2'b11, 4'(i), 4'(i));
        nc_known = 1'b1;

        // Byte enables.
        step(1'b1, 1'b1, 4'd3, 16'hA5C3, 2'b11, 4'd0, 4'd1);
        step(1'b1, 1'b1, 4'd3, 16'hFF00, 2'b01, 4'd0, 4'd1);
        idle(4'd3, 4'd3);
        check("be merge rd_a", 32'(rd_a[0]), 32'hA500);
        check("be merge rd_b", 32'(rd_b[0]), 32'hA500);

        // Same-cycle bypass on a combinational port.
        step(1'b1, 1'b1, 4'd7, 16'h1234, 2'b11, 4'd0, 4'd0);
        step(1'b1, 1'b1, 4'd7, 16'hBEEF, 2'b10, 4'd7, 4'd6);
        check("bypass lat0 rd_a", 32'(rd_a[0]), 32'hBE34);
        check("bypass lat0 rd_b", 32'(rd_b[0]), 32'h0000);
        check("no-bypass lat0 rd_a", 32'(rd_a[1]), 32'h1234);

        // Registered read: read-first versus write-first.
        step(1'b1, 1'b1, 4'd2, 16'h5555, 2'b11, 4'd2, 4'd2);
        idle(4'd2, 4'd2);
        check("lat1 read-first", 32'(rd_a[2]), 32'h0000);
        check("lat1 write-first", 32'(rd_a[3]), 32'h5555);

        // Reset mid-sweep restarts it; a write during the sweep is lost.
        step(1'b0, 1'b0, '0, '0, 2'b00, '0, '0);
        for (int i = 0; i < 8; i++) step(1'b1, (i == 5), 4'd9, 16'h1111, 2'b11, 4'd9, 4'd9);
        step(1'b0, 1'b0, '0, '0, 2'b00, '0, '0);
        sweep_watch();
        idle(4'd9, 4'd9);
        check("dropped write", 32'(rd_a[0]), 32'h0000);

        // Random 2R1W traffic with one reset half-way.
        for (int n = 0; n < 800; n++) begin
            if (n == 400) begin
                step(1'b0, 1'b0, '0, '0, 2'b00, '0, '0);
                sweep_watch();
            end
            r_we = 1'($urandom);
            r_wa = 4'($urandom);
            r_wd = 16'($urandom);
            r_be = 2'($urandom);
            r_ra = ($urandom_range(0, 2) == 0) ? r_wa : 4'($urandom);
            r_rb = ($urandom_range(0, 2) == 0) ? r_wa : 4'($urandom);
            step(1'b1, r_we, r_wa, r_wd, r_be, r_ra, r_rb);
        end

        idle(4'd0, 4'd0);
        @(posedge clk);
        @(negedge clk);
        #1;
        check("scoreboard drained", 32'(sb.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
